adder_checker: RTL and testbench



---
 rtl/adder_checker_pkg.sv | 30 +++
 rtl/adder_checker_if.sv | 16 +
 rtl/adder_ref_model.sv | 14 +
 rtl/adder_checker.sv | 162 ++++++++++++++++
 tb/tb_adder_checker.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/adder_checker_pkg.sv
// adder_checker_pkg: shared types and width helpers for the adder self-test block.
//   state_t     - checker FSM states
//   VEC_W/CNT_W - vector and error-counter widths for a given operand width
//   TMR_W       - settle-timer width for a given settle window
package adder_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Width of the {a, b, c_in} vector.
    function automatic int unsigned VEC_W(input int unsigned width);
        return 2 * width + 1;
    endfunction

    // Error counter is one bit wider than the vector so it can hold the full vector count.
    function automatic int unsigned CNT_W(input int unsigned width);
        return 2 * width + 2;
    endfunction

    // Timer counts down from settle-1 to 0; keep at least one bit.
    function automatic int unsigned TMR_W(input int unsigned settle);
        return (settle <= 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/adder_checker_if.sv
// adder_checker_if: bus between the checker and the adder under test.
//   a, b, c_in - operands and carry-in (driven by the checker)
//   c_out, s   - carry-out and sum (driven by the adder)
//   master: checker side, slave: adder side
interface adder_checker_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             c_out;
    logic [WIDTH-1:0] s;

    modport master (output a, b, c_in, input  c_out, s);
    modport slave  (input  a, b, c_in, output c_out, s);
endinterface

// File: rtl/adder_ref_model.sv
// adder_ref_model: combinational golden adder.
//   i_a, i_b  - operands
//   i_c_in    - carry-in
//   o_exp_c   - {carry, sum}, zero-extended a + b + c_in
module adder_ref_model #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic [WIDTH:0]   o_exp_c
);
    assign o_exp_c = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_c_in);
endmodule

// File: rtl/adder_checker.sv
// adder_checker: exhaustive stimulus/response self-test for a ripple/full adder.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse, honoured from IDLE only
//   bus        - adder bus (master): drives a/b/c_in, samples c_out/s
//   busy, done, pass, err_count, fail_vec - run status and results
// Build option: ADDER_CHECKER_STOP_ON_FAIL_EN stops the run at the first mismatch.
module adder_checker
    import adder_checker_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    adder_checker_if.master            bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W(WIDTH)-1:0]    err_count,
    output logic [VEC_W(WIDTH)-1:0]    fail_vec
);
    localparam int unsigned VW = VEC_W(WIDTH);
    localparam int unsigned CW = CNT_W(WIDTH);
    localparam int unsigned TW = TMR_W(SETTLE_CYCLES);

    state_t           r_state, w_state_nxt;
    logic [VW-1:0]    r_cnt, w_cnt_nxt;
    logic [TW-1:0]    r_tmr, w_tmr_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic             r_c_in, w_c_in_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic [CW-1:0]    r_err, w_err_nxt;
    logic [VW-1:0]    r_fail, w_fail_nxt;
    logic [WIDTH:0]   w_exp;
    logic             w_mismatch;
    logic             w_stop;

    adder_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_c_in  (r_c_in),
        .o_exp_c (w_exp)
    );

    // Mismatch defaults to 1 so an unknown compare result counts as a failure.
    always_comb begin
        w_mismatch = 1'b1;
        if ({bus.c_out, bus.s} == w_exp) w_mismatch = 1'b0;
    end

`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch || (r_cnt == '1);
`else
    assign w_stop = (r_cnt == '1);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = DRIVE;
            DRIVE:   w_state_nxt = SETTLE;
            SETTLE:  if (r_tmr == '0) w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = w_stop ? DONE : DRIVE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered datapath and status outputs.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_tmr_nxt  = r_tmr;
        w_a_nxt    = r_a;
        w_b_nxt    = r_b;
        w_c_in_nxt = r_c_in;
        w_busy_nxt = r_busy;
        w_done_nxt = r_done;
        w_pass_nxt = r_pass;
        w_err_nxt  = r_err;
        w_fail_nxt = r_fail;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_nxt  = '0;
                    w_err_nxt  = '0;
                    w_fail_nxt = '0;
                    w_done_nxt = 1'b0;
                    w_pass_nxt = 1'b0;
                    w_busy_nxt = 1'b1;
                end
            end
            DRIVE: begin
                {w_a_nxt, w_b_nxt, w_c_in_nxt} = r_cnt;
                w_tmr_nxt = TW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (r_tmr != '0) w_tmr_nxt = r_tmr - TW'(1);
            end
            SAMPLE: begin
                if (w_mismatch) begin
                    if (r_err != '1) w_err_nxt = r_err + CW'(1);
                    if (r_err == '0) w_fail_nxt = r_cnt;
                end
                if (!w_stop) w_cnt_nxt = r_cnt + VW'(1);
            end
            DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
                w_pass_nxt = (r_err == '0);
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tmr  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c_in <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_fail <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tmr  <= w_tmr_nxt;
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_c_in <= w_c_in_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_pass <= w_pass_nxt;
            r_err  <= w_err_nxt;
            r_fail <= w_fail_nxt;
        end
    end

    assign bus.a     = r_a;
    assign bus.b     = r_b;
    assign bus.c_in  = r_c_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed bench for adder_checker with WIDTH=1 and WIDTH=2 instances.
// Each instance is attached to a behavioural adder with a selectable fault.
module tb_adder_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic [1:0] mode1 = 2'd0;   // 0 good, 1 S stuck-at-0, 2 C_out inverted
    logic [1:0] mode2 = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_checker_if #(.WIDTH(1)) if1 ();
    adder_checker_if #(.WIDTH(2)) if2 ();

    logic       busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] fail1;
    logic       busy2, done2, pass2;
    logic [5:0] err2;
    logic [4:0] fail2;

    adder_checker #(.WIDTH(1), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    adder_checker #(.WIDTH(2), .SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(if2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
    );

    // Behavioural adders under test with fault injection.
    logic [1:0] sum1;
    logic [2:0] sum2;
    assign sum1 = {1'b0, if1.a} + {1'b0, if1.b} + {1'b0, if1.c_in};
    assign sum2 = {1'b0, if2.a} + {1'b0, if2.b} + {2'b00, if2.c_in};
    assign if1.s     = (mode1 == 2'd1) ? 1'b0  : sum1[0];
    assign if1.c_out = (mode1 == 2'd2) ? ~sum1[1] : sum1[1];
    assign if2.s     = (mode2 == 2'd1) ? 2'b00 : sum2[1:0];
    assign if2.c_out = (mode2 == 2'd2) ? ~sum2[2] : sum2[2];

    logic [2:0] vec1;
    assign vec1 = {if1.a, if1.b, if1.c_in};

    typedef struct {
        logic [1:0] mode;
        logic       repulse;
        logic       exp_pass;
        logic [3:0] exp_err;
        logic [2:0] exp_fail;
        int         exp_cycles;
        logic [2:0] exp_hold;
    } tv_t;

    tv_t tv [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One WIDTH=1 run from IDLE, checked cycle by cycle against the table entry.
    task automatic run1(input int idx);
        tv_t v;
        int  n;
        v = tv[idx];
        mode1 = v.mode;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (n < 300) begin
            start1 = v.repulse && (n == 10 || n == 32);
            if (done1) break;
            if (n == 0) chk("run_busy0", {busy1, done1}, 2'b10);
            else        chk("run_vec", {busy1, done1, vec1}, {1'b1, 1'b0, 3'((n - 1) / 4)});
            @(negedge clk);
            n++;
        end
        start1 = 1'b0;
        chk("run_cycles", 64'(n), 64'(v.exp_cycles));
        chk("run_pass", pass1, v.exp_pass);
        chk("run_err", err1, v.exp_err);
        chk("run_fail_vec", fail1, v.exp_fail);
        chk("run_busy_end", busy1, 1'b0);
        chk("run_hold_vec", vec1, v.exp_hold);
        repeat (3) @(negedge clk);
        chk("hold_status", {busy1, done1, pass1, err1, fail1},
            {1'b0, 1'b1, v.exp_pass, v.exp_err, v.exp_fail});
    endtask

    // One WIDTH=2 run from IDLE; checks latency and final results.
    task automatic run2(input logic [1:0] m, input logic ep, input logic [5:0] ee,
                        input logic [4:0] ef, input int ecyc);
        int n;
        mode2 = m;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (n < 400 && !done2) begin
            @(negedge clk);
            n++;
        end
        chk("w2_cycles", 64'(n), 64'(ecyc));
        chk("w2_result", {busy2, done2, pass2, err2, fail2}, {1'b0, 1'b1, ep, ee, ef});
    endtask

    initial begin
        // exp_cycles counts clocks from the start edge to done seen high.
        tv[0] = '{mode: 2'd0, repulse: 1'b0, exp_pass: 1'b1, exp_err: 4'd0,
                  exp_fail: 3'b000, exp_cycles: 33, exp_hold: 3'b111};
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
        tv[1] = '{mode: 2'd1, repulse: 1'b0, exp_pass: 1'b0, exp_err: 4'd1,
                  exp_fail: 3'b001, exp_cycles: 9, exp_hold: 3'b001};
        tv[2] = '{mode: 2'd2, repulse: 1'b0, exp_pass: 1'b0, exp_err: 4'd1,
                  exp_fail: 3'b000, exp_cycles: 5, exp_hold: 3'b000};
`else
        tv[1] = '{mode: 2'd1, repulse: 1'b0, exp_pass: 1'b0, exp_err: 4'd4,
                  exp_fail: 3'b001, exp_cycles: 33, exp_hold: 3'b111};
        tv[2] = '{mode: 2'd2, repulse: 1'b0, exp_pass: 1'b0, exp_err: 4'd8,
                  exp_fail: 3'b000, exp_cycles: 33, exp_hold: 3'b111};
`endif
        tv[3] = '{mode: 2'd0, repulse: 1'b1, exp_pass: 1'b1, exp_err: 4'd0,
                  exp_fail: 3'b000, exp_cycles: 33, exp_hold: 3'b111};

        // Reset state.
        #12;
        chk("reset_w1", {vec1, busy1, done1, pass1, err1, fail1}, 64'd0);
        chk("reset_w2", {if2.a, if2.b, if2.c_in, busy2, done2, pass2, err2, fail2}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {busy1, done1}, 2'b00);

        for (int i = 0; i < 4; i++) run1(i);

        // Reset asserted for one cycle while vector 5 is on the bus.
        mode1 = 2'd0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (22) @(negedge clk);
        chk("pre_reset_vec", {busy1, vec1}, {1'b1, 3'd5});
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {vec1, busy1, done1, pass1, err1, fail1}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {vec1, busy1, done1, pass1, err1, fail1}, 64'd0);
        run1(0);
        run1(1);

        // WIDTH=2: 32 vectors, 4 clocks each, plus the DONE cycle.
        run2(2'd0, 1'b1, 6'd0, 5'b00000, 129);
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
        run2(2'd2, 1'b0, 6'd1, 5'b00000, 5);
`else
        run2(2'd2, 1'b0, 6'd32, 5'b00000, 129);
`endif
        run2(2'd0, 1'b1, 6'd0, 5'b00000, 129);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
